// File: rtl/rgmii_rx_decoder.sv
// RGMII receive decoder: rebuilds GMII bytes from IDDR nibble pairs, strips preamble/SFD and
// streams payload with last/error markers. Optional in-band link status: RGMII_INBAND_STATUS_EN.
module rgmii_rx_decoder #(
  parameter int unsigned MAX_LEN = 1522
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rxd_q1,
  input  logic [3:0] rxd_q2,
  input  logic       rx_ctl_q1,
  input  logic       rx_ctl_q2,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       stat_frame_ok,
  output logic       stat_frame_err,
  output logic       stat_pre_err,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       link_full_duplex,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  logic [7:0] rx_byte;
  logic       dv;
  logic       er;

  assign rx_byte = {rxd_q2, rxd_q1};
  assign dv      = rx_ctl_q1;
  assign er      = rx_ctl_q1 ^ rx_ctl_q2;

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [15:0] len_q, len_d;
  logic        err_seen_q, err_seen_d;
  logic        hold_vld_q, hold_vld_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        frame_ok_q, frame_ok_d;
  logic        frame_err_q, frame_err_d;
  logic        pre_err_q, pre_err_d;

  // Handshake: m_tvalid qualifies m_tdata/m_tlast/m_tuser for exactly one cycle; there is
  // no tready, so the consumer must accept every beat on the cycle it is presented.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    len_d       = len_q;
    err_seen_d  = err_seen_q;
    hold_vld_d  = hold_vld_q;
    hold_d      = hold_q;
    tdata_d     = tdata_q;
    tvalid_d    = 1'b0;
    tlast_d     = 1'b0;
    tuser_d     = 1'b0;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    pre_err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dv) begin
          if (rx_byte == 8'h55) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else begin
            pre_err_d = 1'b1;
            state_d   = S_DROP;
          end
        end
      end
      S_PREAMBLE: begin
        if (!dv) begin
          state_d = S_IDLE;
        end else if (!er && rx_byte == 8'h55) begin
          if (pre_cnt_q != 3'd7) pre_cnt_d = pre_cnt_q + 3'd1;
        end else if (!er && rx_byte == 8'hD5) begin
          state_d    = S_DATA;
          len_d      = 16'd0;
          err_seen_d = 1'b0;
          hold_vld_d = 1'b0;
        end else begin
          pre_err_d = 1'b1;
          state_d   = S_DROP;
        end
      end
      S_DATA: begin
        if (hold_vld_q && len_q == MAX_LEN_W) begin
          // The MAX_LEN-th byte sits in hold: close the frame as bad, discard the rest.
          tvalid_d    = 1'b1;
          tdata_d     = hold_q;
          tlast_d     = 1'b1;
          tuser_d     = 1'b1;
          frame_err_d = 1'b1;
          hold_vld_d  = 1'b0;
          state_d     = dv ? S_DROP : S_IDLE;
        end else if (dv) begin
          if (hold_vld_q) begin
            tvalid_d = 1'b1;
            tdata_d  = hold_q;
          end
          hold_d     = rx_byte;
          hold_vld_d = 1'b1;
          len_d      = len_q + 16'd1;
          if (er) err_seen_d = 1'b1;
        end else begin
          if (hold_vld_q) begin
            tvalid_d    = 1'b1;
            tdata_d     = hold_q;
            tlast_d     = 1'b1;
            tuser_d     = err_seen_q;
            frame_ok_d  = !err_seen_q;
            frame_err_d = err_seen_q;
          end
          hold_vld_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_DROP: begin
        if (!dv) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pre_cnt_q   <= 3'd0;
      len_q       <= 16'd0;
      err_seen_q  <= 1'b0;
      hold_vld_q  <= 1'b0;
      hold_q      <= 8'd0;
      tdata_q     <= 8'd0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tuser_q     <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pre_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      len_q       <= len_d;
      err_seen_q  <= err_seen_d;
      hold_vld_q  <= hold_vld_d;
      hold_q      <= hold_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tuser_q     <= tuser_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      pre_err_q   <= pre_err_d;
    end
  end

  assign m_tdata        = tdata_q;
  assign m_tvalid       = tvalid_q;
  assign m_tlast        = tlast_q;
  assign m_tuser        = tuser_q;
  assign stat_frame_ok  = frame_ok_q;
  assign stat_frame_err = frame_err_q;
  assign stat_pre_err   = pre_err_q;
  assign dbg_state      = state_q;

`ifdef RGMII_INBAND_STATUS_EN
  logic       link_up_q, link_up_d;
  logic [1:0] link_speed_q, link_speed_d;
  logic       link_fd_q, link_fd_d;

  // Inter-frame status is only trusted when both nibbles agree and no error is signalled.
  always_comb begin
    link_up_d    = link_up_q;
    link_speed_d = link_speed_q;
    link_fd_d    = link_fd_q;
    if (state_q == S_IDLE && !dv && !er && rxd_q1 == rxd_q2) begin
      link_up_d    = rxd_q1[0];
      link_speed_d = rxd_q1[2:1];
      link_fd_d    = rxd_q1[3];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      link_up_q    <= 1'b0;
      link_speed_q <= 2'b00;
      link_fd_q    <= 1'b0;
    end else begin
      link_up_q    <= link_up_d;
      link_speed_q <= link_speed_d;
      link_fd_q    <= link_fd_d;
    end
  end

  assign link_up          = link_up_q;
  assign link_speed       = link_speed_q;
  assign link_full_duplex = link_fd_q;
`else
  assign link_up          = 1'b1;
  assign link_speed       = 2'b10;
  assign link_full_duplex = 1'b1;
`endif

endmodule

// File: tb/tb_rgmii_rx_decoder.sv
// Bench for rgmii_rx_decoder: two instances (MAX_LEN 1522 and 64) share one random RGMII
// stream; a frame-level model predicts each instance's beats into expected queues.
`timescale 1ns/1ps
module tb_rgmii_rx_decoder;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] rxd_q1 = 4'd0;
  logic [3:0] rxd_q2 = 4'd0;
  logic       rx_ctl_q1 = 1'b0;
  logic       rx_ctl_q2 = 1'b0;

  logic [7:0] a_tdata, b_tdata;
  logic a_tvalid, a_tlast, a_tuser, a_ok, a_err, a_pre, a_link_up, a_fd;
  logic b_tvalid, b_tlast, b_tuser, b_ok, b_err, b_pre, b_link_up, b_fd;
  logic [1:0] a_speed, b_speed, a_dbg, b_dbg;

  rgmii_rx_decoder #(.MAX_LEN(1522)) dut_a (
    .clk(clk), .rst(rst), .rxd_q1(rxd_q1), .rxd_q2(rxd_q2),
    .rx_ctl_q1(rx_ctl_q1), .rx_ctl_q2(rx_ctl_q2),
    .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tlast(a_tlast), .m_tuser(a_tuser),
    .stat_frame_ok(a_ok), .stat_frame_err(a_err), .stat_pre_err(a_pre),
    .link_up(a_link_up), .link_speed(a_speed), .link_full_duplex(a_fd),
    .dbg_state(a_dbg)
  );

  rgmii_rx_decoder #(.MAX_LEN(64)) dut_b (
    .clk(clk), .rst(rst), .rxd_q1(rxd_q1), .rxd_q2(rxd_q2),
    .rx_ctl_q1(rx_ctl_q1), .rx_ctl_q2(rx_ctl_q2),
    .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tlast(b_tlast), .m_tuser(b_tuser),
    .stat_frame_ok(b_ok), .stat_frame_err(b_err), .stat_pre_err(b_pre),
    .link_up(b_link_up), .link_speed(b_speed), .link_full_duplex(b_fd),
    .dbg_state(b_dbg)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [9:0] exp_a[$];   // {tuser_on_last, tlast, tdata}
  logic [9:0] exp_b[$];
  int exp_pre = 0;
  int got_pre_a = 0;
  int got_pre_b = 0;
  logic [7:0] pl[0:127];
  logic       pe[0:127];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame of len payload bytes yields min(len, max) beats; the last is bad if any
  // delivered byte carried er or the frame reached max.
  task automatic push_beats(input int which, input int len, input int max_len);
    int n;
    logic user;
    logic [9:0] e;
    n = (len < max_len) ? len : max_len;
    user = (len >= max_len);
    for (int i = 0; i < n; i++) if (pe[i]) user = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = {(i == n - 1) && user, i == n - 1, pl[i]};
      if (which == 0) exp_a.push_back(e);
      else exp_b.push_back(e);
    end
  endtask

  task automatic model_frame(input int len);
    push_beats(0, len, 1522);
    push_beats(1, len, 64);
  endtask

  // ---------------- driver tasks ----------------
  task automatic put(input logic [7:0] b, input logic dv, input logic er);
    rxd_q1    = b[3:0];
    rxd_q2    = b[7:4];
    rx_ctl_q1 = dv;
    rx_ctl_q2 = dv ^ er;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) put(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic drive_frame(input int pre_n, input int len);
    for (int i = 0; i < pre_n; i++) put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < len; i++) put(pl[i], 1'b1, pe[i]);
    gap($urandom_range(1, 3));
  endtask

  task automatic fill_random(input int len, input logic er_en);
    for (int i = 0; i < len; i++) begin
      pl[i] = 8'($urandom);
      pe[i] = er_en && ($urandom_range(0, 15) == 0);
    end
  endtask

  task automatic drop_tail();
    int k;
    k = $urandom_range(0, 5);
    for (int i = 0; i < k; i++) put(8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
    gap($urandom_range(1, 3));
  endtask

  // ---------------- compare process ----------------
  task automatic chk_port(input int which, input logic v, input logic l, input logic u,
                          input logic [7:0] d, input logic ok, input logic ferr);
    logic [9:0] e;
    string nm;
    int sz;
    nm = (which == 0) ? "dut_a" : "dut_b";
    sz = (which == 0) ? exp_a.size() : exp_b.size();
    vectors++;
    if (v) begin
      if (sz == 0) begin
        miscompares++;
        $display("FAIL %s_beat: got unexpected beat data=%02h last=%0b, expected no beat", nm, d, l);
      end else begin
        if (which == 0) e = exp_a.pop_front();
        else e = exp_b.pop_front();
        if ({l & u, l, d} !== e || ok !== (e[8] & ~e[9]) || ferr !== (e[8] & e[9])) begin
          miscompares++;
          $display("FAIL %s_beat: got data=%02h last=%0b user=%0b ok=%0b err=%0b, expected data=%02h last=%0b user=%0b",
                   nm, d, l, u, ok, ferr, e[7:0], e[8], e[9]);
        end
      end
    end else if (l | ok | ferr) begin
      miscompares++;
      $display("FAIL %s_idle: got last=%0b ok=%0b err=%0b without tvalid, expected 0", nm, l, ok, ferr);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs",
            {a_tvalid, a_tlast, a_tuser, a_ok, a_err, a_pre, a_tdata,
             b_tvalid, b_tlast, b_tuser, b_ok, b_err, b_pre, b_tdata}, 32'd0);
    end else begin
      chk_port(0, a_tvalid, a_tlast, a_tuser, a_tdata, a_ok, a_err);
      chk_port(1, b_tvalid, b_tlast, b_tuser, b_tdata, b_ok, b_err);
      got_pre_a += int'(a_pre);
      got_pre_b += int'(b_pre);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int len, k;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
`ifndef RGMII_INBAND_STATUS_EN
    check("link_const", {a_link_up, a_speed, a_fd}, 32'hD);
`endif
    gap(2);

    // Good 64-byte frame 0x01..0x40
    for (int i = 0; i < 64; i++) begin pl[i] = 8'(i + 1); pe[i] = 1'b0; end
    model_frame(64);
    check("model_len_a", exp_a.size(), 64);
    check("model_last_a", exp_a[63], {1'b0, 1'b1, 8'h40});
    check("model_last_b", exp_b[63], {1'b1, 1'b1, 8'h40});
    for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) begin
      put(pl[i], 1'b1, 1'b0);
      if (i == 0) check("lat_hold", a_tvalid, 0);
      if (i == 1) check("lat_first", {a_tvalid, a_tdata}, {1'b1, 8'h01});
    end
    put(8'h00, 1'b0, 1'b0);
    check("first_tlast", {a_tvalid, a_tlast, a_tuser, a_ok, a_err, a_tdata}, {5'b11010, 8'h40});
    gap(2);

    // Same frame, er on payload byte 10
    pe[9] = 1'b1;
    model_frame(64);
    check("model_er_last", exp_a[$], {1'b1, 1'b1, 8'h40});
    drive_frame(7, 64);
    pe[9] = 1'b0;

    // Malformed first byte, then a dropped preamble, then a good frame
    put(8'hAA, 1'b1, 1'b0);
    exp_pre++;
    check("pre_err_pulse", a_pre, 1);
    for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) put(8'($urandom), 1'b1, 1'b0);
    check("drop_quiet", a_tvalid, 0);
    put(8'h00, 1'b0, 1'b0);
    fill_random(20, 1'b0);
    model_frame(20);
    drive_frame(3, 20);

    // Oversize frame: 100 bytes against MAX_LEN 64 on dut_b
    fill_random(100, 1'b0);
    model_frame(100);
    check("model_trunc_b", exp_b.size(), 64);
    check("model_full_a", exp_a.size(), 100);
    drive_frame(7, 100);

    // SFD then immediate dv drop
    put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    put(8'h00, 1'b0, 1'b0);
    check("empty_frame", {a_tvalid, a_ok, a_err, b_tvalid}, 0);
    gap(1);

    // Reset during payload byte 20
    fill_random(20, 1'b0);
    for (int i = 0; i < 19; i++) begin
      exp_a.push_back({2'b00, pl[i]});
      exp_b.push_back({2'b00, pl[i]});
    end
    for (int i = 0; i < 7; i++) put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) put(pl[i], 1'b1, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset_clear", {a_tvalid, a_tlast, a_tuser, a_ok, a_err, a_pre, a_tdata}, 0);
    rx_ctl_q1 = 1'b0;
    rx_ctl_q2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_queue_a", exp_a.size(), 0);
    check("reset_queue_b", exp_b.size(), 0);
    fill_random(30, 1'b1);
    model_frame(30);
    drive_frame(7, 30);

    // Randomized traffic
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          len = $urandom_range(0, 120);
          fill_random(len, 1'($urandom_range(0, 2) == 0));
          model_frame(len);
          drive_frame($urandom_range(1, 7), len);
        end
        3: begin
          b = 8'($urandom);
          if (b == 8'h55) b = 8'h54;
          put(b, 1'b1, 1'($urandom_range(0, 1)));
          exp_pre++;
          drop_tail();
        end
        4: begin
          k = $urandom_range(1, 6);
          for (int i = 0; i < k; i++) put(8'h55, 1'b1, 1'b0);
          case ($urandom_range(0, 2))
            0: begin
              b = 8'($urandom);
              if (b == 8'h55 || b == 8'hD5) b = 8'h00;
              put(b, 1'b1, 1'b0);
            end
            1: put(8'h55, 1'b1, 1'b1);
            default: put(8'hD5, 1'b1, 1'b1);
          endcase
          exp_pre++;
          drop_tail();
        end
        default: begin
          k = $urandom_range(1, 7);
          for (int i = 0; i < k; i++) put(8'h55, 1'b1, 1'b0);
          gap($urandom_range(1, 3));
        end
      endcase
    end

`ifdef RGMII_INBAND_STATUS_EN
    put(8'h00, 1'b0, 1'b0);
    check("link_zero", {a_link_up, a_speed, a_fd}, 0);
    put(8'hDD, 1'b0, 1'b0);
    check("link_update", {a_link_up, a_speed, a_fd}, 32'hD);
    put(8'h0E, 1'b0, 1'b0);
    check("link_mismatch_hold", {a_link_up, a_speed, a_fd}, 32'hD);
    put(8'hEE, 1'b0, 1'b1);
    check("link_er_hold", {a_link_up, a_speed, a_fd}, 32'hD);
`endif

    gap(4);
    @(negedge clk);
    #1;
    check("drain_a", exp_a.size(), 0);
    check("drain_b", exp_b.size(), 0);
    check("pre_count_a", got_pre_a, exp_pre);
    check("pre_count_b", got_pre_b, exp_pre);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
